// File: rtl/spi_slave_tx_ctrl.sv
// ---------------------------------------------------------------------------
// spi_slave_tx_ctrl
//
// Purpose:
//   Sequences the SPI slave transmit shifter for one read burst. Pulls 32-bit
//   words from a valid/ready source (the TX FIFO read port), loads each word
//   into the shifter, programs the shift count for single-line or quad mode
//   and tracks how many words of the burst are still to be sent. Lives in the
//   sclk-derived clock domain, on the same edge that clocks the shifter.
//
// Ports:
//   clk_i            in   1      clock (shifter edge)
//   rst_ni           in   1      asynchronous active-low reset
//   cs_i             in   1      chip select, high = deselected; synchronous abort
//   start_i          in   1      start burst (only looked at in IDLE)
//   quad_i           in   1      1 = quad, 0 = single line (latched at start)
//   len_i            in   LEN_W  burst length in words (latched at start)
//   busy_o           out  1      burst in progress
//   done_o           out  1      one-cycle pulse when a burst completes
//   underrun_o       out  1      one-cycle pulse when PAD_WORD is substituted
//   rdata_i          in   32     source word
//   rvalid_i         in   1      source word valid
//   rready_o         out  1      pop source (handshake = rvalid_i & rready_o)
//   tx_data_o        out  32     word to shifter
//   tx_data_valid_o  out  1      load tx_data_o into the shifter this cycle
//   tx_counter_o     out  8      shift count target: 7 quad, 31 single
//   tx_counter_upd_o out  1      load tx_counter_o / restart shifter this cycle
//   tx_done_i        in   1      shifter is on the last shift of its word
//
// Optional feature (macro SPI_TX_CTRL_UNDERRUN_CNT_EN):
//   underrun_cnt_o   out  16     saturating count of underrun_o pulses since
//                                reset, cleared when a start is accepted
// ---------------------------------------------------------------------------
module spi_slave_tx_ctrl #(
  parameter int          LEN_W    = 16,
  parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cs_i,
  input  logic             start_i,
  input  logic             quad_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  input  logic [31:0]      rdata_i,
  input  logic             rvalid_i,
  output logic             rready_o,
  output logic [31:0]      tx_data_o,
  output logic             tx_data_valid_o,
  output logic [7:0]       tx_counter_o,
  output logic             tx_counter_upd_o,
  input  logic             tx_done_i
`ifdef SPI_TX_CTRL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             quad_q;
  logic             load;

  // A load happens in the single LOAD cycle and again, with no bubble, on
  // every tx_done_i while words remain. Deselect kills the load outright so
  // the source is never popped on an abort cycle.
  always_comb begin
    load = 1'b0;
    if (!cs_i) begin
      if (state == LOAD) begin
        load = 1'b1;
      end else if (state == SHIFT && tx_done_i && remaining != LEN_ZERO) begin
        load = 1'b1;
      end
    end
  end

  assign busy_o           = (state != IDLE);
  assign rready_o         = load;
  assign tx_data_valid_o  = load;
  assign tx_counter_upd_o = load;

  // An empty source never stalls the line: the pad word goes out instead and
  // the burst carries on as if a real word had been sent.
  assign tx_data_o    = load ? (rvalid_i ? rdata_i : PAD_WORD) : 32'h0000_0000;
  assign underrun_o   = load & ~rvalid_i;
  assign tx_counter_o = quad_q ? 8'd7 : 8'd31;

  // Burst sequencer. remaining holds the words still to be loaded after the
  // current one; it is armed with the full length at start and decremented on
  // each load, so reaching zero on tx_done_i marks the end of the burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      remaining <= LEN_ZERO;
      quad_q    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (cs_i) begin
        state     <= IDLE;
        remaining <= LEN_ZERO;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (len_i != LEN_ZERO) begin
                state     <= LOAD;
                remaining <= len_i;
                quad_q    <= quad_i;
              end else begin
                done_o <= 1'b1;
              end
            end
          end
          LOAD: begin
            remaining <= remaining - LEN_ONE;
            state     <= SHIFT;
          end
          SHIFT: begin
            if (tx_done_i) begin
              if (remaining != LEN_ZERO) begin
                remaining <= remaining - LEN_ONE;
              end else begin
                state  <= IDLE;
                done_o <= 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            remaining <= LEN_ZERO;
          end
        endcase
      end
    end
  end

`ifdef SPI_TX_CTRL_UNDERRUN_CNT_EN
  logic        start_ok;
  logic [15:0] underrun_cnt;

  assign start_ok = (state == IDLE) && start_i && !cs_i;

  // Per-burst underrun tally: cleared when a new burst is accepted, so after
  // back-to-back bursts it reflects only the most recent one. Sticks at max.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrun_cnt <= 16'h0000;
    end else if (start_ok) begin
      underrun_cnt <= 16'h0000;
    end else if (underrun_o && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'h0001;
    end
  end

  assign underrun_cnt_o = underrun_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_tx_ctrl
//
// Purpose:
//   Self-checking bench for spi_slave_tx_ctrl. The source FIFO is a queue
//   owned by the bench; a simple shifter stand-in raises tx_done_i a fixed
//   number of cycles after each load. Expected behaviour is derived from
//   word counts: the first load follows start, each further load rides on a
//   tx_done_i while fewer than len words have gone out, and the tx_done_i
//   after the last word ends the burst with a done pulse.
//
// Ports: none (top-level bench). Honours SPI_TX_CTRL_UNDERRUN_CNT_EN.
// ---------------------------------------------------------------------------
module tb_spi_slave_tx_ctrl;

  localparam int          LEN_W = 16;
  localparam logic [31:0] PAD   = 32'h0000_0000;

  logic             clk;
  logic             rst_n;
  logic             cs;
  logic             start;
  logic             quad;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             underrun;
  logic [31:0]      rdata;
  logic             rvalid;
  logic             rready;
  logic [31:0]      tx_data;
  logic             tx_data_valid;
  logic [7:0]       tx_counter;
  logic             tx_counter_upd;
  logic             tx_done;
`ifdef SPI_TX_CTRL_UNDERRUN_CNT_EN
  logic [15:0]      underrun_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int expCnt   = 0;

  logic [31:0] src[$];

  spi_slave_tx_ctrl #(.LEN_W(LEN_W), .PAD_WORD(PAD)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cs_i            (cs),
    .start_i         (start),
    .quad_i          (quad),
    .len_i           (len),
    .busy_o          (busy),
    .done_o          (done),
    .underrun_o      (underrun),
    .rdata_i         (rdata),
    .rvalid_i        (rvalid),
    .rready_o        (rready),
    .tx_data_o       (tx_data),
    .tx_data_valid_o (tx_data_valid),
    .tx_counter_o    (tx_counter),
    .tx_counter_upd_o(tx_counter_upd),
    .tx_done_i       (tx_done)
`ifdef SPI_TX_CTRL_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o  (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic c, input logic td);
    start   = st;
    cs      = c;
    tx_done = td;
    rvalid  = (src.size() != 0);
    rdata   = (src.size() != 0) ? src[0] : 32'h0000_0000;
  endtask

  task automatic checkUnderrunCount(input string tag);
`ifdef SPI_TX_CTRL_UNDERRUN_CNT_EN
    checkOutput(tag, {16'h0000, underrun_cnt}, expCnt);
`else
    if (tag.len() == 0) $display("[TB] empty tag");
`endif
  endtask

  // One complete burst. abortAt >= 0 raises cs together with the first
  // tx_done_i seen once abortAt words have been loaded.
  task automatic runBurst(input int blen, input bit bquad, input int nsrc,
                          input int period, input int abortAt);
    int          loads;
    int          sinceLoad;
    bit          txd;
    bit          abort;
    bit          expLoad;
    bit          lastDone;
    bit          finished;
    bit          expDone;
    logic [31:0] expWord;

    src.delete();
    for (int i = 0; i < nsrc; i++) src.push_back($urandom);

    quad = bquad;
    len  = blen[LEN_W-1:0];
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("start_busy", busy, 1'b0);
    checkOutput("start_pop", rready, 1'b0);
    checkOutput("start_done", done, 1'b0);
    @(posedge clk); #1;
    expCnt = 0;

    if (blen == 0) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("len0_done", done, 1'b1);
      checkOutput("len0_busy", busy, 1'b0);
      checkOutput("len0_pop", rready, 1'b0);
      checkUnderrunCount("len0_ucnt");
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("len0_done_clr", done, 1'b0);
      checkOutput("len0_busy2", busy, 1'b0);
      @(posedge clk); #1;
      return;
    end

    loads     = 0;
    sinceLoad = -1000;
    finished  = 0;
    expDone   = 0;
    for (int c = 0; c < 5000 && !finished; c++) begin
      txd      = (sinceLoad == period - 1);
      abort    = txd && (loads == abortAt);
      expLoad  = !abort && (c == 0 || (txd && loads < blen));
      lastDone = !abort && txd && (loads >= blen);
      applyStimulus(1'b0, abort, txd);
      @(negedge clk);
      checkOutput("busy", busy, 1'b1);
      checkOutput("load_valid", tx_data_valid, expLoad);
      checkOutput("pop", rready, expLoad);
      checkOutput("cnt_upd", tx_counter_upd, expLoad);
      checkOutput("done_mid", done, 1'b0);
      checkOutput("tx_counter", tx_counter, bquad ? 32'd7 : 32'd31);
      if (expLoad) begin
        expWord = (src.size() != 0) ? src[0] : PAD;
        checkOutput("tx_data", tx_data, expWord);
        checkOutput("underrun", underrun, src.size() == 0);
        if (src.size() == 0 && expCnt < 65535) expCnt++;
      end else begin
        checkOutput("no_underrun", underrun, 1'b0);
      end
      @(posedge clk); #1;
      if (expLoad) begin
        if (src.size() != 0) void'(src.pop_front());
        loads++;
        sinceLoad = 0;
      end else begin
        sinceLoad++;
      end
      if (abort) begin
        finished = 1;
      end else if (lastDone) begin
        finished = 1;
        expDone  = 1;
      end
    end
    checkOutput("burst_timeout", finished, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("end_done", done, expDone);
    checkOutput("end_busy", busy, 1'b0);
    checkOutput("end_pop", rready, 1'b0);
    checkUnderrunCount("end_ucnt");
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("end_done_clr", done, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int rl;
    int rn;
    int rab;

    rst_n   = 1'b0;
    cs      = 1'b0;
    start   = 1'b0;
    quad    = 1'b0;
    len     = '0;
    tx_done = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'h0000_0000;
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_underrun", underrun, 1'b0);
    checkOutput("rst_pop", rready, 1'b0);
    checkOutput("rst_valid", tx_data_valid, 1'b0);
    checkOutput("rst_upd", tx_counter_upd, 1'b0);
    checkOutput("rst_data", tx_data, 32'h0);
    checkOutput("rst_counter", tx_counter, 32'd31);
    checkUnderrunCount("rst_ucnt");
    #22;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] len=3 single, full source, 32-cycle words");
    runBurst(3, 1'b0, 3, 32, -1);

    $display("[TB] len=2 quad, one word in source");
    runBurst(2, 1'b1, 1, 8, -1);

    $display("[TB] len=0 start");
    runBurst(0, 1'b0, 2, 4, -1);

    $display("[TB] abort with cs on a tx_done mid-burst, then a normal burst");
    runBurst(3, 1'b0, 3, 5, 1);
    runBurst(2, 1'b0, 2, 4, -1);

    $display("[TB] reset during SHIFT");
    src.delete();
    for (int i = 0; i < 4; i++) src.push_back($urandom);
    quad = 1'b1;
    len  = 16'd4;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    void'(src.pop_front());
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pre_rst_load", tx_data_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_valid", tx_data_valid, 1'b0);
    checkOutput("mid_rst_pop", rready, 1'b0);
    checkOutput("mid_rst_upd", tx_counter_upd, 1'b0);
    checkOutput("mid_rst_data", tx_data, 32'h0);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_counter", tx_counter, 32'd31);
    expCnt = 0;
    checkUnderrunCount("mid_rst_ucnt");
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runBurst(1, 1'b0, 1, 3, -1);

    $display("[TB] back-to-back underrun bursts");
    runBurst(3, 1'b1, 0, 3, -1);
    runBurst(2, 1'b0, 1, 3, -1);
    runBurst(4, 1'b1, 1, 2, -1);

    $display("[TB] randomized bursts");
    for (int k = 0; k < 8; k++) begin
      rl  = $urandom_range(1, 5);
      rn  = $urandom_range(0, rl);
      rab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rl) : -1;
      runBurst(rl, 1'($urandom_range(0, 1)), rn, $urandom_range(2, 6), rab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
